// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin resource arbiter.
//   arb_state_e : arbiter FSM state (IDLE = no grant, BUSY = grant active)
//   idx_width   : width of a requester index for a given requester count
//   cnt_width   : width of a counter that must be able to hold max_hold
package arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    function automatic int idx_width(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

    function automatic int cnt_width(input int max_hold);
        return $clog2(max_hold + 1);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick.
//   req     : request vector
//   ptr     : index with the highest priority this round
//   winner  : first set request at or above ptr, wrapping at NUM_REQ
//   any_req : at least one request is set
// Works for any NUM_REQ >= 2, including non powers of two: the rotation
// wraps at NUM_REQ rather than at 2**IDX_W.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   winner,
    output logic               any_req
);

    logic [NUM_REQ-1:0] rot;
    int                 off;
    int                 pos;
    logic               found;

    always_comb begin
        rot   = '0;
        off   = 0;
        pos   = 0;
        found = 1'b0;

        // rotate so that requester ptr lands at bit 0
        for (int i = 0; i < NUM_REQ; i++) begin
            pos = i + int'(ptr);
            if (pos >= NUM_REQ) pos = pos - NUM_REQ;
            rot[i] = req[pos];
        end

        // priority-encode the lowest set bit of the rotated vector
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && rot[i]) begin
                off   = i;
                found = 1'b1;
            end
        end

        // un-rotate back to a requester index
        pos = off + int'(ptr);
        if (pos >= NUM_REQ) pos = pos - NUM_REQ;
        winner = IDX_W'(pos);
    end

    assign any_req = |req;

endmodule

// File: rtl/shared_res_rr_arbiter.sv
// Round-robin arbiter sharing one single-ported resource among NUM_REQ
// requesters.
//   clk       : clock, everything on posedge
//   rst       : synchronous active-high reset
//   req       : level request per requester, held until served
//   res_done  : one-cycle pulse from the resource, transaction complete
//   gnt       : one-hot grant, zero when idle
//   gnt_idx   : index of the granted requester, meaningful while gnt_valid
//   gnt_valid : a grant is active
//   res_start : one-cycle pulse in the first grant cycle
//   timeout   : one-cycle pulse when a grant is force-released
//   dbg_state : current FSM state
// Handshake: a grant starts with res_start in its first cycle and ends on
// the cycle after res_done, after the owner drops its request, or after
// MAX_HOLD grant cycles. Priority of release causes: done, drop, timeout.
// All outputs are registered; one idle cycle always separates two grants.
module shared_res_rr_arbiter
    import arb_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int MAX_HOLD = 16,
    parameter int IDX_W    = idx_width(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               res_done,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_valid,
    output logic               res_start,
    output logic               timeout,
    output arb_state_e         dbg_state
);

    localparam int CNT_W = cnt_width(MAX_HOLD);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_HOLD - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    arb_state_e         state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_REQ-1:0] gnt_d;
    logic [IDX_W-1:0]   idx_d;
    logic               valid_d;
    logic               start_d;
    logic               timeout_d;

    logic [IDX_W-1:0]   winner;
    logic               any_req;
    logic [IDX_W-1:0]   ptr_after;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req     (req),
        .ptr     (ptr_q),
        .winner  (winner),
        .any_req (any_req)
    );

    // the released owner gets the lowest priority next round
    assign ptr_after = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        gnt_d     = gnt;
        idx_d     = gnt_idx;
        valid_d   = gnt_valid;
        start_d   = 1'b0;
        timeout_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                gnt_d   = '0;
                idx_d   = '0;
                valid_d = 1'b0;
                cnt_d   = '0;
                if (any_req) begin
                    state_d = BUSY;
                    for (int i = 0; i < NUM_REQ; i++) begin
                        gnt_d[i] = (winner == IDX_W'(i));
                    end
                    idx_d   = winner;
                    valid_d = 1'b1;
                    start_d = 1'b1;
                end
            end

            BUSY: begin
                // cnt_q counts completed grant cycles; equals MAX_HOLD-1
                // during the MAX_HOLD-th cycle
                cnt_d = cnt_q + 1'b1;
                if (res_done || !req[gnt_idx] || (cnt_q == LAST_CNT)) begin
                    state_d   = IDLE;
                    gnt_d     = '0;
                    idx_d     = '0;
                    valid_d   = 1'b0;
                    cnt_d     = '0;
                    ptr_d     = ptr_after;
                    timeout_d = !res_done && req[gnt_idx];
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            cnt_q     <= '0;
            gnt       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
            res_start <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            gnt       <= gnt_d;
            gnt_idx   <= idx_d;
            gnt_valid <= valid_d;
            res_start <= start_d;
            timeout   <= timeout_d;
        end
    end

    assign dbg_state = state_q;

endmodule
